segment_sequencer: RTL and testbench
====================================

# segment_sequencer

Consumes 4-byte motion segment records from the SPI-fed segment FIFO and turns each one into a direction level plus a train of timed step pulses. It sits between the FIFO read port and the step/dir output pins, and is the only FIFO reader. It pops records only when a whole record is buffered, so the FIFO stays record-aligned.

## Interface
Parameters:
- `WORD_SIZE`, 8: FIFO word width. Must be 8.
- `RECORD_WORDS`, 4: words per record. Must be 4.
- `SIZE_WIDTH`, 7: width of `fifo_size`.
- `PULSE_WIDTH`, 8: step high time in clocks, ≥1.
- `DIR_SETUP`, 4: clocks from a `dir` update to the first step edge, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, active-low. One clock; reset is asynchronous and active-low.
- `enable` in 1: allows new records to be fetched.
- `abort` in 1: synchronous request to drop the current segment.
- `fifo_size` in SIZE_WIDTH: number of words currently in the FIFO.
- `fifo_data` in 8: FIFO read data. Valid the cycle after `fifo_read_en`.
- `fifo_read_en` out 1: pops one word.
- `step` out 1: step pulse.
- `dir` out 1: direction level.
- `busy` out 1: high in any state other than IDLE.
- `segment_done` out 1: one-cycle pulse when a segment completes.
- `segments_done` out 8: completed-segment counter, wraps.
- `underrun` out 1: sticky flag.

## Operation
- Record layout is little-endian. Byte0 = steps[7:0]. Byte1 = {dir, steps[14:8]}. Byte2 = period[7:0]. Byte3 = period[15:8].
- `period` is the number of clocks between step rising edges. The effective period is `max(period, 2*PULSE_WIDTH)`, compared in 16 bits.
- States:
  - IDLE: go to FETCH when `enable` && `fifo_size >= 4`.
  - FETCH: `fifo_read_en` is high for exactly 4 consecutive cycles. Bytes are captured 1 cycle later, on the capture cycles numbered 1 to 4.
  - LOAD (1 cycle): register `dir`, steps and the clamped period.
    - steps = 0: go to DONE.
    - Otherwise go to SETUP.
  - SETUP: wait DIR_SETUP cycles, then go to RUN.
  - RUN: each period begins with `step` high for PULSE_WIDTH cycles, then low for the remainder of the period. The step counter decrements on each rising edge. When the last period has elapsed, go to DONE.
  - DONE (1 cycle): pulse `segment_done` and increment `segments_done` (255 → 0).
    - If `enable` && `fifo_size >= 4`: go to FETCH (back-to-back).
    - Else: go to IDLE.
- `dir` changes only in LOAD and holds its value until the next LOAD.
- `enable` low mid-segment: the current segment finishes normally, then the block goes to IDLE.
- `underrun`:
  - Set in DONE when `enable` = 1 and `fifo_size < 4`.
  - Cleared while `enable` = 0.
  - A set and a clear in the same cycle resolve to cleared.
- `abort`:
  - In LOAD, SETUP or RUN: `step` goes low the next cycle and the block goes to IDLE. `segment_done` does not pulse and the counter is not incremented.
  - In FETCH: all 4 reads still complete, then the record is discarded and the block goes to IDLE.
  - In IDLE or DONE: ignored.

## Timing
- Reset values: `fifo_read_en` = 0, `step` = 0, `dir` = 0, `busy` = 0, `segment_done` = 0, `segments_done` = 0, `underrun` = 0. The state is IDLE.
- All outputs are registered.
- Reset asserted mid-segment: outputs go to their reset values immediately (asynchronously). No further reads are issued.
- Cycle numbering: cycle 0 is the IDLE cycle in which the start condition is seen.
  - Cycles 1–4: `fifo_read_en` high.
  - Cycles 2–5: bytes 0–3 captured.
  - Cycle 6: LOAD. `dir` is valid from cycle 7.
  - First `step` rise at cycle 7+DIR_SETUP.
- Step edges:
  - Step k rises at (7+DIR_SETUP) + (k-1)·P, where P is the effective period.
  - DONE is at (7+DIR_SETUP) + steps·P.
- Back-to-back segments:
  - FETCH starts in the cycle after DONE.
  - The first step of the new segment rises at DONE + 7 + DIR_SETUP.
- Reads are never issued when `fifo_size < 4`.
- No stray `step` pulse on any state transition.

## Test plan
- Reset, then load the record {0x03,0x80,0x20,0x00} with enable=1 → 4 reads. `dir` = 1. 3 pulses of 8 cycles each, rising edges 32 cycles apart, first rise at cycle 11. Then `segment_done` pulses and `segments_done` = 1.
- Load a record with period = 5 → effective period 16: rises 16 cycles apart, high 8 cycles.
- Load two records back-to-back → the second FETCH starts the cycle after DONE, `underrun` = 0. After the second DONE with the FIFO empty and enable=1 → `underrun` = 1. Drop enable → `underrun` = 0.
- Load a record with steps = 0 → no pulse, `segment_done` pulses at cycle 7, counter increments.
- Assert `abort` in cycle 2 of FETCH → exactly 4 reads, no pulses, back in IDLE. Assert `abort` mid-RUN with `step` high → `step` = 0 the next cycle, counter unchanged.
- Put only 3 words in the FIFO → `fifo_read_en` stays 0. Apply reset mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/segment_sequencer.sv
// segment_sequencer: pops 4-byte motion records from the segment FIFO and
// plays each one out as a direction level followed by a train of timed step
// pulses. Records are only fetched when a complete record is buffered, so
// the FIFO always stays record-aligned.
module segment_sequencer #(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 4,
  parameter int SIZE_WIDTH   = 7,
  parameter int PULSE_WIDTH  = 8,
  parameter int DIR_SETUP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  abort,
  input  logic [SIZE_WIDTH-1:0] fifo_size,
  input  logic [WORD_SIZE-1:0]  fifo_data,
  output logic                  fifo_read_en,
  output logic                  step,
  output logic                  dir,
  output logic                  busy,
  output logic                  segment_done,
  output logic [7:0]            segments_done,
  output logic                  underrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SETUP = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Shortest legal period keeps a low phase at least as long as the pulse.
  localparam logic [15:0] MIN_PERIOD   = 16'(2 * PULSE_WIDTH);
  localparam logic [15:0] PULSE_CLKS   = 16'(PULSE_WIDTH);
  localparam logic [15:0] SETUP_LAST   = 16'(DIR_SETUP - 1);
  localparam logic [15:0] FETCH_LAST   = 16'(RECORD_WORDS);
  localparam logic [SIZE_WIDTH-1:0] RECORD_LEVEL = SIZE_WIDTH'(RECORD_WORDS);

  state_t        state_reg, state_next;
  // Shared cycle counter: read/capture slot in FETCH, wait in SETUP,
  // position within the current period in RUN.
  logic [15:0]   cnt_reg, cnt_next;
  // Periods still to play, including the one in progress.
  logic [14:0]   steps_left_reg, steps_left_next;
  logic [15:0]   period_reg, period_next;
  logic          abort_pend_reg, abort_pend_next;
  logic [31:0]   rec_reg;
  logic          capture;
  logic [1:0]    byte_idx;
  logic [15:0]   raw_period;
  logic          start_ok;

  logic          read_en_next, step_next, dir_next, busy_next, done_next;

  assign start_ok   = enable && (fifo_size >= RECORD_LEVEL);
  assign raw_period = rec_reg[31:16];
  // Read data lags the read strobe by one cycle, so capture slot n holds byte n-1.
  assign byte_idx   = cnt_reg[1:0] - 2'd1;

  // Next-state, counters and registered-output precursors.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    steps_left_next = steps_left_reg;
    period_next     = period_reg;
    abort_pend_next = abort_pend_reg;
    dir_next        = dir;
    capture         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next      = FETCH;
          cnt_next        = '0;
          abort_pend_next = 1'b0;
        end
      end
      FETCH: begin
        capture = (cnt_reg != 16'd0);
        if (abort) abort_pend_next = 1'b1;
        if (cnt_reg == FETCH_LAST) begin
          // An abort seen during the fetch only takes effect once the whole
          // record has been popped, keeping the FIFO aligned.
          state_next = (abort_pend_reg || abort) ? IDLE : LOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      LOAD: begin
        dir_next        = rec_reg[15];
        steps_left_next = rec_reg[14:0];
        period_next     = (raw_period < MIN_PERIOD) ? MIN_PERIOD : raw_period;
        cnt_next        = '0;
        if (abort)                      state_next = IDLE;
        else if (rec_reg[14:0] == 15'd0) state_next = DONE;
        else                            state_next = SETUP;
      end
      SETUP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == SETUP_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == period_reg - 16'd1) begin
          cnt_next = '0;
          if (steps_left_reg == 15'd1) state_next = DONE;
          else                         steps_left_next = steps_left_reg - 15'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      DONE: begin
        if (start_ok) begin
          state_next      = FETCH;
          cnt_next        = '0;
          abort_pend_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are derived from the next state so they register cleanly.
    read_en_next = (state_next == FETCH) && (cnt_next < FETCH_LAST);
    step_next    = (state_next == RUN) && (cnt_next < PULSE_CLKS);
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      steps_left_reg <= '0;
      period_reg     <= '0;
      abort_pend_reg <= 1'b0;
      fifo_read_en   <= 1'b0;
      step           <= 1'b0;
      dir            <= 1'b0;
      busy           <= 1'b0;
      segment_done   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      steps_left_reg <= steps_left_next;
      period_reg     <= period_next;
      abort_pend_reg <= abort_pend_next;
      fifo_read_en   <= read_en_next;
      step           <= step_next;
      dir            <= dir_next;
      busy           <= busy_next;
      segment_done   <= done_next;
    end
  end

  // Assemble the little-endian record one byte per capture slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rec_reg <= '0;
    else if (capture) rec_reg[8*byte_idx +: 8] <= fifo_data[7:0];
  end

  // Completed-segment counter, wraps at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 segments_done <= '0;
    else if (state_reg == DONE) segments_done <= segments_done + 8'd1;
  end

  // Sticky starvation flag; dropping enable always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           underrun <= 1'b0;
    else if (!enable)                                     underrun <= 1'b0;
    else if (state_reg == DONE && fifo_size < RECORD_LEVEL) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_segment_sequencer.sv
// Testbench for segment_sequencer: a byte-queue FIFO model feeds records and
// each segment's expected waveform is computed from the record timing rules.
module tb_segment_sequencer;
  localparam int PW = 8;
  localparam int DS = 4;

  logic       clk = 1'b0;
  logic       rst_n, enable, abort;
  logic [6:0] fifo_size;
  logic [7:0] fifo_data;
  logic       fifo_read_en, step, dir, busy, segment_done, underrun;
  logic [7:0] segments_done;

  segment_sequencer #(
    .WORD_SIZE(8), .RECORD_WORDS(4), .SIZE_WIDTH(7),
    .PULSE_WIDTH(PW), .DIR_SETUP(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .fifo_size(fifo_size), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .step(step), .dir(dir), .busy(busy),
    .segment_done(segment_done), .segments_done(segments_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  bit exp_underrun = 0;
  bit in_done = 0;
  bit prev_dir = 0;

  // FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_read_en && q.size() > 0) fifo_data <= q.pop_front();
  end

  task automatic chk(input string tag, input int t, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp_v);
    end
  endtask

  task automatic push_record(input int st, input bit d, input int per);
    logic [14:0] s;
    logic [15:0] p;
    s = st[14:0];
    p = per[15:0];
    q.push_back(s[7:0]);
    q.push_back({d, s[14:8]});
    q.push_back(p[7:0]);
    q.push_back(p[15:8]);
    fifo_size = 7'(q.size());
  endtask

  // Advance one cycle; counter and underrun follow from the DONE/enable rules.
  task automatic tick();
    int sz;
    sz = q.size();
    @(posedge clk);
    if (!enable) exp_underrun = 0;
    else if (in_done && sz < 4) exp_underrun = 1;
    if (in_done) exp_count = (exp_count + 1) % 256;
    in_done = 0;
    #1;
    fifo_size = 7'(q.size());
    chk("segments_done", 0, 16'(segments_done), 16'(exp_count));
    chk("underrun", 0, 16'(underrun), 16'(exp_underrun));
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_read_en", i, 16'(fifo_read_en), 16'd0);
      chk("idle_step", i, 16'(step), 16'd0);
      chk("idle_busy", i, 16'(busy), 16'd0);
      chk("idle_dir", i, 16'(dir), 16'(prev_dir));
    end
  endtask

  // Called in cycle 0 of a segment; returns in its DONE cycle (or earlier
  // when aborted / stopped). Cycle-by-cycle expectations from the timing rules.
  task automatic run_seg(input int steps, input bit d, input int period,
                         input int abort_at, input int drop_en_at, input int stop_at);
    int p, s0, done_t, end_t;
    bit fetch_abort, live;
    bit e_rd, e_step, e_busy, e_done, e_dir;
    p = (period < 2*PW) ? 2*PW : period;
    s0 = 7 + DS;
    done_t = (steps == 0) ? 7 : s0 + steps*p;
    fetch_abort = (abort_at >= 1 && abort_at <= 5);
    end_t = done_t;
    if (fetch_abort) end_t = 6;
    else if (abort_at >= 6 && abort_at < done_t) end_t = abort_at + 1;
    if (stop_at > 0 && stop_at < end_t) end_t = stop_at;
    for (int t = 1; t <= end_t; t++) begin
      tick();
      e_rd = (t >= 1 && t <= 4);
      if (fetch_abort) begin
        e_busy = (t <= 5); e_step = 0; e_done = 0; e_dir = prev_dir;
      end else begin
        live   = (abort_at < 0) || (t <= abort_at);
        e_busy = live && (t <= done_t);
        e_step = live && (t >= s0) && (t < s0 + steps*p) && (((t - s0) % p) < PW);
        e_done = live && (t == done_t);
        e_dir  = (t >= 7) ? d : prev_dir;
      end
      chk("read_en", t, 16'(fifo_read_en), 16'(e_rd));
      chk("step", t, 16'(step), 16'(e_step));
      chk("busy", t, 16'(busy), 16'(e_busy));
      chk("segment_done", t, 16'(segment_done), 16'(e_done));
      chk("dir", t, 16'(dir), 16'(e_dir));
      abort = (t == abort_at);
      if (t == drop_en_at) enable = 0;
      if (t == done_t && abort_at < 0) in_done = 1;
    end
    abort = 0;
    if (!fetch_abort) prev_dir = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read_en"}, 0, 16'(fifo_read_en), 16'd0);
    chk({tag, "_step"}, 0, 16'(step), 16'd0);
    chk({tag, "_dir"}, 0, 16'(dir), 16'd0);
    chk({tag, "_busy"}, 0, 16'(busy), 16'd0);
    chk({tag, "_segment_done"}, 0, 16'(segment_done), 16'd0);
    chk({tag, "_segments_done"}, 0, 16'(segments_done), 16'd0);
    chk({tag, "_underrun"}, 0, 16'(underrun), 16'd0);
  endtask

  initial begin
    int st, per, k, off, a;
    bit d;
    rst_n = 0; enable = 0; abort = 0; fifo_size = 0; fifo_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    tick();

    // Reference record: 3 steps, dir=1, period 0x20.
    enable = 1;
    push_record(3, 1, 32'h20);
    run_seg(3, 1, 32'h20, -1, -1, -1);
    tick();

    // Period below the minimum is stretched to 2*PW.
    st = $urandom_range(1, 3);
    push_record(st, $urandom % 2 == 1, 5);
    run_seg(st, q[1][7], 5, -1, -1, -1);
    tick();

    // Two records back to back, then starvation and clear.
    enable = 0;
    tick();
    st = $urandom_range(1, 3); per = $urandom_range(0, 40); d = ($urandom % 2 == 1);
    push_record(st, d, per);
    k = $urandom_range(1, 3); a = $urandom_range(0, 40);
    push_record(k, !d, a);
    enable = 1;
    run_seg(st, d, per, -1, -1, -1);
    run_seg(k, !d, a, -1, -1, -1);
    tick();
    chk("underrun_set", 0, 16'(underrun), 16'd1);
    enable = 0;
    tick();
    chk("underrun_clr", 0, 16'(underrun), 16'd0);

    // Zero-step record completes straight from LOAD.
    enable = 1;
    push_record(0, 1, 40);
    run_seg(0, 1, 40, -1, -1, -1);
    tick();

    // Abort during FETCH: all four reads, then idle.
    push_record(2, 0, 20);
    run_seg(2, 0, 20, 2, -1, -1);
    idle_check(3);

    // Abort mid-RUN while step is high.
    per = $urandom_range(16, 30);
    k = $urandom_range(1, 3); off = $urandom_range(0, PW - 1);
    a = 7 + DS + (k - 1)*per + off;
    push_record(3, 0, per);
    run_seg(3, 0, per, a, -1, -1);
    idle_check(3);

    // Enable dropped mid-segment: finishes, then waits with a record pending.
    enable = 0;
    tick();
    push_record(2, 1, 18);
    push_record(1, 0, 16);
    enable = 1;
    run_seg(2, 1, 18, -1, 9, -1);
    idle_check(4);
    enable = 1;
    run_seg(1, 0, 16, -1, -1, -1);
    tick();

    // Random records, occasionally with a long (high-byte) period.
    for (int i = 0; i < 6; i++) begin
      st = $urandom_range(0, 4);
      d = ($urandom % 2 == 1);
      per = ($urandom % 4 == 0) ? $urandom_range(256, 300) : $urandom_range(0, 40);
      if (per > 100) st = 1;
      push_record(st, d, per);
      run_seg(st, d, per, -1, -1, -1);
      tick();
    end

    // Only three words buffered: no reads may start.
    q.push_back(8'h02); q.push_back(8'h80); q.push_back(8'h10);
    fifo_size = 7'(q.size());
    idle_check(6);
    q.push_back(8'h00);
    fifo_size = 7'(q.size());
    run_seg(2, 1, 16, -1, -1, 7 + DS + 2);
    chk("pre_reset_step", 0, 16'(step), 16'd1);

    // Asynchronous reset mid-RUN.
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    exp_count = 0; exp_underrun = 0; prev_dir = 0; in_done = 0;
    q.delete();
    fifo_size = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    idle_check(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
